// File: rtl/lane_traffic_ctrl_pkg.sv
// lane_traffic_ctrl_pkg: shared playfield geometry, default lane tables and jitter LFSR helpers
package lane_traffic_ctrl_pkg;
  localparam int SCREEN_W = 640;
  localparam int CAR_W = 32;
  localparam int DEF_WRAP_X = SCREEN_W + CAR_W;
  localparam int DEF_TICK_DIV = 400000;
  localparam logic [7:0] DEF_LANE_DIR = 8'b10101010;
  localparam logic [31:0] DEF_LANE_BASE = 32'h21432143;
  localparam logic [79:0] DEF_LANE_INIT = {10'd560, 10'd480, 10'd400, 10'd320, 10'd240, 10'd160, 10'd80, 10'd0};
`ifdef CAR_JITTER_EN
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction
`endif
endpackage

// File: rtl/lane_traffic_ctrl_lane_mover.sv
// lane_traffic_ctrl_lane_mover: one lane's registered x with clamped step and ring wrap
module lane_traffic_ctrl_lane_mover
  import lane_traffic_ctrl_pkg::*;
#(
  parameter int X_W = 10,
  parameter int SPEED_W = 5,
  parameter int WRAP_X = DEF_WRAP_X,
  parameter int MAX_STEP = 31
) (
  input  logic               clk,
  input  logic               dir_i,
  input  logic [3:0]         base_i,
  input  logic [SPEED_W-1:0] bonus_i,
  input  logic               jitter_i,
  input  logic               tick_en_i,
  input  logic               load_i,
  input  logic [X_W-1:0]     init_x_i,
  output logic [X_W-1:0]     x_o
);
  localparam int SW = SPEED_W + 2;
  localparam int AW = X_W + 1;
  localparam logic [AW-1:0] WRAP = AW'(WRAP_X);
  logic [SW-1:0] sum;
  logic [AW-1:0] step, xe, fwd;
  logic [X_W-1:0] x_q, x_d;
  always_comb begin
    sum = SW'(base_i) + SW'(bonus_i) + SW'(jitter_i);
    step = (int'(sum) > MAX_STEP) ? AW'(MAX_STEP) : AW'(sum);
    xe = AW'(x_q);
    fwd = xe + step;
    x_d = X_W'(dir_i ? ((xe < step) ? xe + WRAP - step : xe - step)
                     : ((fwd >= WRAP) ? fwd - WRAP : fwd));
  end
  always_ff @(posedge clk) x_q <= load_i ? init_x_i : tick_en_i ? x_d : x_q;
  assign x_o = x_q;
endmodule

// File: rtl/lane_traffic_ctrl.sv
// lane_traffic_ctrl: tick divider driving NUM_LANES wrapping car lanes; define CAR_JITTER_EN for LFSR step jitter
module lane_traffic_ctrl
  import lane_traffic_ctrl_pkg::*;
#(
  parameter int NUM_LANES = 8,
  parameter int X_W = 10,
  parameter int SPEED_W = 5,
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int WRAP_X = DEF_WRAP_X,
  parameter int MAX_STEP = 31,
  parameter logic [NUM_LANES-1:0] LANE_DIR = DEF_LANE_DIR,
  parameter logic [4*NUM_LANES-1:0] LANE_BASE = DEF_LANE_BASE,
  parameter logic [NUM_LANES*X_W-1:0] LANE_INIT = DEF_LANE_INIT
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       enable,
  input  logic                       restart,
  input  logic [SPEED_W-1:0]         level_bonus,
  output logic [NUM_LANES*X_W-1:0]   car_x,
  output logic                       tick
);
  localparam int CW = $clog2(TICK_DIV);
  logic [CW-1:0] cnt_q, cnt_d;
  logic tick_q, load, term, tick_en;
  logic [NUM_LANES-1:0] jit;
  // restart shares the reset path so it also beats a coincident terminal count
  always_comb begin
    load = RST | restart;
    term = cnt_q == CW'(TICK_DIV - 1);
    tick_en = enable & term & ~load;
    cnt_d = load ? '0 : !enable ? cnt_q : term ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge CLK) begin
    cnt_q <= cnt_d;
    tick_q <= tick_en;
  end
`ifdef CAR_JITTER_EN
  logic [15:0] lfsr_q;
  always_ff @(posedge CLK) lfsr_q <= load ? LFSR_SEED : tick_en ? lfsr_next(lfsr_q) : lfsr_q;
  assign jit = lfsr_q[NUM_LANES-1:0];
`else
  assign jit = '0;
`endif
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lane_traffic_ctrl_lane_mover #(
      .X_W(X_W), .SPEED_W(SPEED_W), .WRAP_X(WRAP_X), .MAX_STEP(MAX_STEP)
    ) u_mover (
      .clk(CLK),
      .dir_i(LANE_DIR[i]),
      .base_i(LANE_BASE[4*i +: 4]),
      .bonus_i(level_bonus),
      .jitter_i(jit[i]),
      .tick_en_i(tick_en),
      .load_i(load),
      .init_x_i(LANE_INIT[X_W*i +: X_W]),
      .x_o(car_x[X_W*i +: X_W])
    );
  end
  assign tick = tick_q;
endmodule

// File: tb/tb_lane_traffic_ctrl.sv
// tb_lane_traffic_ctrl: randomized and directed checks of lane_traffic_ctrl against a modular-arithmetic lane model
module tb_lane_traffic_ctrl;
  localparam int NL = 8;
  localparam int XW = 10;
  localparam int TD = 4;
  localparam int WX = 672;
  localparam int MS = 31;
  localparam logic [79:0] INIT_P = {10'd0, 10'd300, 10'd5, 10'd671, 10'd0, 10'd100, 10'd1, 10'd670};
  logic CLK = 0, RST = 1, enable = 0, restart = 0;
  logic [4:0] level_bonus = 0;
  logic [NL*XW-1:0] car_x;
  logic tick;
  int init_a[NL] = '{670, 1, 100, 0, 671, 5, 300, 0};
  int base_a[NL] = '{1, 1, 4, 0, 2, 0, 15, 3};
  bit left_a[NL] = '{0, 1, 0, 1, 0, 1, 0, 1};
  int mx[NL];
  int mcnt;
  bit mtick;
  logic [15:0] mlfsr;
  int vectors = 0, miscompares = 0;

  lane_traffic_ctrl #(
    .NUM_LANES(NL), .X_W(XW), .SPEED_W(5), .TICK_DIV(TD), .WRAP_X(WX), .MAX_STEP(MS),
    .LANE_DIR(8'b10101010), .LANE_BASE(32'h3F020411), .LANE_INIT(INIT_P)
  ) dut (
    .CLK(CLK), .RST(RST), .enable(enable), .restart(restart),
    .level_bonus(level_bonus), .car_x(car_x), .tick(tick)
  );

  always #5 CLK = ~CLK;

  function automatic logic [NL*XW-1:0] exp_x();
    logic [NL*XW-1:0] e;
    for (int i = 0; i < NL; i++) e[i*XW +: XW] = XW'(mx[i]);
    return e;
  endfunction

  task automatic model_load();
    for (int i = 0; i < NL; i++) mx[i] = init_a[i];
    mcnt = 0;
    mtick = 0;
    mlfsr = 16'hACE1;
  endtask

  task automatic model_move(input int b);
    int st, j;
    for (int i = 0; i < NL; i++) begin
`ifdef CAR_JITTER_EN
      j = int'(mlfsr[i]);
`else
      j = 0;
`endif
      st = base_a[i] + b + j;
      if (st > MS) st = MS;
      mx[i] = left_a[i] ? (mx[i] - st + WX) % WX : (mx[i] + st) % WX;
    end
    mlfsr = {mlfsr[14:0], mlfsr[15] ^ mlfsr[13] ^ mlfsr[12] ^ mlfsr[10]};
  endtask

  task automatic drive(input bit r, input bit e, input bit rs, input logic [4:0] b);
    RST = r; enable = e; restart = rs; level_bonus = b;
    @(posedge CLK);
    if (r || rs) model_load();
    else if (e) begin
      if (mcnt == TD - 1) begin
        model_move(int'(b));
        mcnt = 0;
        mtick = 1;
      end else begin
        mcnt++;
        mtick = 0;
      end
    end else mtick = 0;
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) drive(1, 1'($urandom), 1'($urandom), 5'($urandom));
    vectors++;
    if (car_x !== INIT_P) begin miscompares++; $display("FAIL reset_car_x got %h exp %h", car_x, INIT_P); end
    vectors++;
    if (tick !== 1'b0) begin miscompares++; $display("FAIL reset_tick got %b exp 0", tick); end
  endtask

  task automatic test_tick_period();
    for (int k = 0; k < 12; k++) begin
      drive(0, 1, 0, 5'd2);
      vectors++;
      if (tick !== (k % 4 == 3)) begin miscompares++; $display("FAIL period_tick k=%0d got %b exp %b", k, tick, k % 4 == 3); end
      vectors++;
      if (car_x !== exp_x()) begin miscompares++; $display("FAIL period_car_x k=%0d got %h exp %h", k, car_x, exp_x()); end
      if (k == 3) begin
        vectors++;
        if (car_x[9:0] !== 10'd1) begin miscompares++; $display("FAIL wrap_right got %0d exp 1", car_x[9:0]); end
        vectors++;
        if (car_x[19:10] !== 10'd670) begin miscompares++; $display("FAIL wrap_left got %0d exp 670", car_x[19:10]); end
      end
    end
  endtask

  task automatic test_clamp();
    drive(0, 0, 1, 5'd0);
    for (int k = 0; k < 3; k++) drive(0, 1, 0, 5'd0);
    drive(0, 1, 0, 5'd31);
    vectors++;
    if (car_x[29:20] !== 10'd131) begin miscompares++; $display("FAIL clamp_lane2 got %0d exp 131", car_x[29:20]); end
    vectors++;
    if (car_x[9:0] !== 10'd29) begin miscompares++; $display("FAIL clamp_lane0 got %0d exp 29", car_x[9:0]); end
    vectors++;
    if (car_x !== exp_x()) begin miscompares++; $display("FAIL clamp_car_x got %h exp %h", car_x, exp_x()); end
  endtask

  task automatic test_pause();
    logic [NL*XW-1:0] held;
    drive(0, 0, 1, 5'd0);
    drive(0, 1, 0, 5'd3);
    drive(0, 1, 0, 5'd3);
    held = car_x;
    for (int k = 0; k < 10; k++) begin
      drive(0, 0, 0, 5'($urandom));
      vectors++;
      if (tick !== 1'b0 || car_x !== held) begin
        miscompares++; $display("FAIL pause k=%0d tick %b car_x %h exp tick 0 car_x %h", k, tick, car_x, held);
      end
    end
    for (int k = 0; k < 2; k++) begin
      drive(0, 1, 0, 5'd3);
      vectors++;
      if (tick !== (k == 1)) begin miscompares++; $display("FAIL resume_tick k=%0d got %b exp %b", k, tick, k == 1); end
    end
    vectors++;
    if (car_x !== exp_x()) begin miscompares++; $display("FAIL resume_car_x got %h exp %h", car_x, exp_x()); end
  endtask

  task automatic test_restart_terminal();
    drive(0, 0, 1, 5'd0);
    for (int k = 0; k < 7; k++) drive(0, 1, 0, 5'd5);
    drive(0, 1, 1, 5'd5);
    vectors++;
    if (car_x !== INIT_P || tick !== 1'b0) begin
      miscompares++; $display("FAIL restart_term car_x %h tick %b exp %h tick 0", car_x, tick, INIT_P);
    end
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, 0, 5'd5);
      vectors++;
      if (tick !== (k == 3)) begin miscompares++; $display("FAIL restart_next_tick k=%0d got %b exp %b", k, tick, k == 3); end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      drive($urandom_range(99) == 0, $urandom_range(4) != 0, $urandom_range(39) == 0,
            ($urandom_range(3) == 0) ? 5'd31 : ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom));
      vectors++;
      if (car_x !== exp_x() || tick !== mtick) begin
        miscompares++; $display("FAIL random k=%0d car_x %h tick %b exp %h tick %b", k, car_x, tick, exp_x(), mtick);
      end
    end
  endtask

  initial begin
    model_load();
    test_reset();
    test_tick_period();
    test_clamp();
    test_pause();
    test_restart_terminal();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
